// File: rtl/skipcnt_pkg.sv
// rtl/skipcnt_pkg.sv - skip_counter defaults, mode encodings and step helper
package skipcnt_pkg;

    localparam int SKIPCNT_WIDTH_D   = 4;
    localparam int SKIPCNT_THRESH_D  = 8;
    localparam int SKIPCNT_STEP_LO_D = 1;
    localparam int SKIPCNT_STEP_HI_D = 2;
    localparam int SKIPCNT_MAX_D     = 15;

    typedef enum logic {
        SKIPCNT_MODE_SKIP = 1'b0,
        SKIPCNT_MODE_LIN  = 1'b1
    } skipcnt_mode_e;

    // Any step beyond MAX always wraps, so MAX+1 is equivalent and fits in WIDTH+1 bits.
    function automatic int skipcnt_clamp_step(input int step, input int max);
        return (step > max) ? max + 1 : step;
    endfunction

endpackage

// File: rtl/skipcnt_next.sv
// rtl/skipcnt_next.sv - combinational next-count and wrap decision
module skipcnt_next
    import skipcnt_pkg::*;
#(
    parameter int WIDTH   = SKIPCNT_WIDTH_D,
    parameter int THRESH  = SKIPCNT_THRESH_D,
    parameter int STEP_LO = SKIPCNT_STEP_LO_D,
    parameter int STEP_HI = SKIPCNT_STEP_HI_D,
    parameter int MAX     = SKIPCNT_MAX_D
) (
    input  logic [WIDTH-1:0] cnt_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] nxt_o,
    output logic             wrap_o
);

    localparam int LO_C = skipcnt_clamp_step(STEP_LO, MAX);
    localparam int HI_C = skipcnt_clamp_step(STEP_HI, MAX);

    localparam logic [WIDTH:0] THRESH_W = THRESH[WIDTH:0];
    localparam logic [WIDTH:0] MAX_W    = MAX[WIDTH:0];
    localparam logic [WIDTH:0] LO_W     = LO_C[WIDTH:0];
    localparam logic [WIDTH:0] HI_W     = HI_C[WIDTH:0];

    logic [WIDTH:0] cnt_ext;
    logic [WIDTH:0] step;
    logic [WIDTH:0] sum;

    always_comb begin
        cnt_ext = {1'b0, cnt_i};
        step    = (mode_i == SKIPCNT_MODE_SKIP && cnt_ext > THRESH_W) ? HI_W : LO_W;
        sum     = cnt_ext + step;
        wrap_o  = (cnt_ext == MAX_W) || (sum > MAX_W);
        nxt_o   = wrap_o ? '0 : sum[WIDTH-1:0];
    end

endmodule

// File: rtl/skip_counter.sv
// rtl/skip_counter.sv - parametrised skip counter; SKIPCNT_WRAPCNT_EN adds wrap_cnt
module skip_counter
    import skipcnt_pkg::*;
#(
    parameter int WIDTH   = SKIPCNT_WIDTH_D,
    parameter int THRESH  = SKIPCNT_THRESH_D,
    parameter int STEP_LO = SKIPCNT_STEP_LO_D,
    parameter int STEP_HI = SKIPCNT_STEP_HI_D,
    parameter int MAX     = SKIPCNT_MAX_D
`ifdef SKIPCNT_WRAPCNT_EN
    ,
    parameter int WRAP_W  = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap,
    output logic             load_err
`ifdef SKIPCNT_WRAPCNT_EN
    ,
    output logic [WRAP_W-1:0] wrap_cnt
`endif
);

    generate
        if (STEP_LO < 1 || STEP_HI < 1 || THRESH >= MAX || MAX > (2**WIDTH) - 1) begin : g_bad_param
            $error("skip_counter: illegal parameter combination");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_W = MAX[WIDTH-1:0];

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             lerr_q, lerr_d;
    logic [WIDTH-1:0] nxt;
    logic             nxt_wrap;

    skipcnt_next #(
        .WIDTH  (WIDTH),
        .THRESH (THRESH),
        .STEP_LO(STEP_LO),
        .STEP_HI(STEP_HI),
        .MAX    (MAX)
    ) u_next (
        .cnt_i (cnt_q),
        .mode_i(mode),
        .nxt_o (nxt),
        .wrap_o(nxt_wrap)
    );

    // Priority: clr > load > en > hold; pulses default low every cycle.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        lerr_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            if (load_val > MAX_W) begin
                cnt_d  = '0;
                lerr_d = 1'b1;
            end else begin
                cnt_d = load_val;
            end
        end else if (en) begin
            cnt_d  = nxt;
            wrap_d = nxt_wrap;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            lerr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            lerr_q <= lerr_d;
        end
    end

    assign cnt      = cnt_q;
    assign wrap     = wrap_q;
    assign load_err = lerr_q;

`ifdef SKIPCNT_WRAPCNT_EN
    logic [WRAP_W-1:0] wcnt_q, wcnt_d;

    always_comb begin
        wcnt_d = wcnt_q;
        if (clr) begin
            wcnt_d = '0;
        end else if (wrap_d && wcnt_q != '1) begin
            wcnt_d = wcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

    assign wrap_cnt = wcnt_q;
`endif

endmodule

// File: tb/tb_skip_counter.sv
// tb/tb_skip_counter.sv - directed bench with per-cycle model compare for skip_counter
module tb_skip_counter;
    import skipcnt_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, clr = 1'b0, load = 1'b0, mode = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [3:0] cnt0, cnt1, cnt2;
    logic       wrap0, wrap1, wrap2;
    logic       lerr0, lerr1, lerr2;
`ifdef SKIPCNT_WRAPCNT_EN
    logic [1:0] wc0;
`endif

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    skip_counter #(
        .WIDTH(4), .THRESH(8), .STEP_LO(1), .STEP_HI(2), .MAX(15)
`ifdef SKIPCNT_WRAPCNT_EN
        , .WRAP_W(2)
`endif
    ) u_def (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .mode(mode), .cnt(cnt0), .wrap(wrap0), .load_err(lerr0)
`ifdef SKIPCNT_WRAPCNT_EN
        , .wrap_cnt(wc0)
`endif
    );

    skip_counter #(
        .WIDTH(4), .THRESH(8), .STEP_LO(1), .STEP_HI(2), .MAX(11)
`ifdef SKIPCNT_WRAPCNT_EN
        , .WRAP_W(8)
`endif
    ) u_m11 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .mode(mode), .cnt(cnt1), .wrap(wrap1), .load_err(lerr1)
`ifdef SKIPCNT_WRAPCNT_EN
        , .wrap_cnt()
`endif
    );

    skip_counter #(
        .WIDTH(4), .THRESH(8), .STEP_LO(1), .STEP_HI(3), .MAX(14)
`ifdef SKIPCNT_WRAPCNT_EN
        , .WRAP_W(8)
`endif
    ) u_s3 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .mode(mode), .cnt(cnt2), .wrap(wrap2), .load_err(lerr2)
`ifdef SKIPCNT_WRAPCNT_EN
        , .wrap_cnt()
`endif
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the counting rules.
    int P_HI[3]  = '{2, 2, 3};
    int P_MAX[3] = '{15, 11, 14};
    int m_cnt[3]  = '{0, 0, 0};
    int m_wrap[3] = '{0, 0, 0};
    int m_lerr[3] = '{0, 0, 0};
    int m_wc = 0;

    always @(posedge clk or negedge rst) begin : model
        int st;
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                m_cnt[i] = 0; m_wrap[i] = 0; m_lerr[i] = 0;
            end
            m_wc = 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                m_wrap[i] = 0;
                m_lerr[i] = 0;
                if (clr) begin
                    m_cnt[i] = 0;
                end else if (load) begin
                    if (int'(load_val) > P_MAX[i]) begin
                        m_cnt[i] = 0; m_lerr[i] = 1;
                    end else begin
                        m_cnt[i] = int'(load_val);
                    end
                end else if (en) begin
                    st = (mode == 1'b0 && m_cnt[i] > 8) ? P_HI[i] : 1;
                    if (m_cnt[i] + st > P_MAX[i]) begin
                        m_cnt[i] = 0; m_wrap[i] = 1;
                    end else begin
                        m_cnt[i] = m_cnt[i] + st;
                    end
                end
            end
            if (clr) m_wc = 0;
            else if (m_wrap[0] == 1 && m_wc < 3) m_wc = m_wc + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("mdl.def.cnt",  int'(cnt0),  m_cnt[0]);
            chk("mdl.def.wrap", int'(wrap0), m_wrap[0]);
            chk("mdl.def.lerr", int'(lerr0), m_lerr[0]);
            chk("mdl.m11.cnt",  int'(cnt1),  m_cnt[1]);
            chk("mdl.m11.wrap", int'(wrap1), m_wrap[1]);
            chk("mdl.m11.lerr", int'(lerr1), m_lerr[1]);
            chk("mdl.s3.cnt",   int'(cnt2),  m_cnt[2]);
            chk("mdl.s3.wrap",  int'(wrap2), m_wrap[2]);
            chk("mdl.s3.lerr",  int'(lerr2), m_lerr[2]);
`ifdef SKIPCNT_WRAPCNT_EN
            chk("mdl.def.wcnt", int'(wc0), m_wc);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int seq_skip[16] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 11, 13, 15, 0, 1, 2, 3};
    int seq_ld[3]    = '{12, 14, 0};
    int seq_wc[5]    = '{1, 2, 3, 3, 3};

    initial begin
        #1 rst = 1'b0;
        #1 chk_on = 1'b1;
        repeat (2) tick();
        chk("rst.cnt", int'(cnt0), 0);
        chk("rst.wrap", int'(wrap0), 0);
        chk("rst.lerr", int'(lerr0), 0);

        rst = 1'b1; en = 1'b1; mode = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("skip.cnt", int'(cnt0), seq_skip[i]);
            chk("skip.wrap", int'(wrap0), (i == 12) ? 1 : 0);
        end

        en = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
        chk("clr.cnt", int'(cnt0), 0);
        mode = 1'b1; en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("lin.cnt", int'(cnt0), (i + 1) % 16);
            chk("lin.wrap", int'(wrap0), (i == 15) ? 1 : 0);
        end

        mode = 1'b0; load = 1'b1; load_val = 4'd10; tick(); load = 1'b0;
        chk("ld10.cnt", int'(cnt0), 10);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ld10.seq", int'(cnt0), seq_ld[i]);
            chk("ld10.wrap", int'(wrap0), (i == 2) ? 1 : 0);
        end

        en = 1'b0; load = 1'b1; load_val = 4'd12; tick(); load = 1'b0;
        chk("ld12.def.cnt", int'(cnt0), 12);
        chk("ld12.def.lerr", int'(lerr0), 0);
        chk("ld12.m11.cnt", int'(cnt1), 0);
        chk("ld12.m11.lerr", int'(lerr1), 1);
        tick();
        chk("ld12.m11.lerr_drop", int'(lerr1), 0);

        load = 1'b1; load_val = 4'd7; tick();
        chk("ld7.cnt", int'(cnt0), 7);
        clr = 1'b1; en = 1'b1; load_val = 4'd13; tick();
        clr = 1'b0; load = 1'b0; en = 1'b0;
        chk("prio.cnt", int'(cnt0), 0);
        chk("prio.wrap", int'(wrap0), 0);
        chk("prio.m11.lerr", int'(lerr1), 0);

        load = 1'b1; load_val = 4'd5; tick(); load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold.cnt", int'(cnt0), 5);
        end

        load = 1'b1; load_val = 4'd9; tick(); load = 1'b0; en = 1'b1;
        tick();
        chk("s3.cnt12", int'(cnt2), 12);
        tick();
        chk("s3.cnt0", int'(cnt2), 0);
        chk("s3.wrap", int'(wrap2), 1);
        en = 1'b0;

        load = 1'b1; load_val = 4'd15; tick(); load = 1'b0;
        chk("pre_arst.m11.lerr", int'(lerr1), 1);
        #2 rst = 1'b0;
        #1;
        chk("arst.cnt", int'(cnt0), 0);
        chk("arst.m11.lerr", int'(lerr1), 0);
        rst = 1'b1;

        load = 1'b1; load_val = 4'd15; tick(); load = 1'b0; en = 1'b1; tick(); en = 1'b0;
        chk("pre_arst.wrap", int'(wrap0), 1);
        #2 rst = 1'b0;
        #1;
        chk("arst.wrap", int'(wrap0), 0);
        chk("arst.cnt2", int'(cnt0), 0);
        rst = 1'b1;

        for (int k = 0; k < 5; k++) begin
            load = 1'b1; load_val = 4'd15; tick(); load = 1'b0;
            en = 1'b1; tick(); en = 1'b0;
            chk("wc.wrap", int'(wrap0), 1);
`ifdef SKIPCNT_WRAPCNT_EN
            chk("wc.val", int'(wc0), seq_wc[k]);
`endif
        end
        clr = 1'b1; tick(); clr = 1'b0;
        chk("wc.clr.cnt", int'(cnt0), 0);
`ifdef SKIPCNT_WRAPCNT_EN
        chk("wc.clr", int'(wc0), 0);
`endif
        tick();
        chk_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
